// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and helpers for the ahb_modport subordinate.
//   htrans_e  : transfer type encoding (IDLE, BUSY, NONSEQ, SEQ)
//   OKAY/ERROR: HRESP encodings
//   hsize_e   : transfer size encoding, bytes = 2**HSIZE
//   lane_mask : byte lanes covered by a size-aligned access inside one data word
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_e;

  localparam logic OKAY  = 1'b0;
  localparam logic ERROR = 1'b1;

  typedef enum logic [2:0] {
    SizeByte  = 3'd0,
    SizeHalf  = 3'd1,
    SizeWord  = 3'd2,
    SizeDword = 3'd3,
    Size4Word = 3'd4,
    Size8Word = 3'd5,
    Size16Wd  = 3'd6,
    Size32Wd  = 3'd7
  } hsize_e;

  // Lanes addr_lo..addr_lo+2**size-1 after aligning addr_lo down to the access size.
  // Only meaningful for sizes that fit in the word; wider sizes are rejected upstream.
  function automatic logic [7:0] lane_mask(input logic [2:0] addr_lo, input logic [2:0] size,
                                           input int unsigned strb_w);
    int unsigned nbytes;
    int unsigned off;
    int unsigned m;
    nbytes = 32'd1 << size;
    off    = 32'(addr_lo) & (strb_w - 32'd1) & ~(nbytes - 32'd1);
    m      = ((32'd1 << nbytes) - 32'd1) << off;
    return m[7:0];
  endfunction

endpackage

// File: rtl/ahb_modport_mem.sv
// Single-port byte-enabled RAM backing the ahb_modport subordinate.
//   HCLK  : clock, writes on rising edge
//   we    : write enable
//   be    : per-byte write enables, lane 0 = wdata[7:0]
//   idx   : word index (shared by read and write)
//   wdata : write data
//   rdata : combinational read of word idx
module ahb_modport_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic                          HCLK,
  input  logic                          we,
  input  logic [DATA_WIDTH/8-1:0]       be,
  input  logic [$clog2(MEM_DEPTH)-1:0]  idx,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic [DATA_WIDTH-1:0]         rdata
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge HCLK) begin
    if (we) begin
      for (int i = 0; i < StrbW; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/ahb_modport.sv
// AHB-Lite subordinate: word-organised, byte-strobed local memory with programmable
// wait states and the two-cycle ERROR response.
//   HCLK, HRESET          : clock and synchronous active-high reset
//   HSELx, HADDR, HTRANS  : address phase select/address/type
//   HWRITE, HSIZE         : direction and size (bytes = 2**HSIZE)
//   HBURST, HMASTLOCK,
//   HPROT                 : accepted, not used
//   HWDATA, HWSTRB        : data phase write data and byte strobes
//   HREADY                : bus-level ready
//   HRDATA, HREADYOUT,
//   HRESP                 : data phase response
module ahb_modport
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    HSELx,
  input  logic [ADDR_WIDTH-1:0]   HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic                    HMASTLOCK,
  input  logic [3:0]              HPROT,
  input  logic [DATA_WIDTH-1:0]   HWDATA,
  input  logic [DATA_WIDTH/8-1:0] HWSTRB,
  input  logic                    HREADY,
  output logic [DATA_WIDTH-1:0]   HRDATA,
  output logic                    HREADYOUT,
  output logic                    HRESP
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned Lsb   = $clog2(StrbW);
  localparam int unsigned IdxW  = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [2:0]              size_q;
  logic [3:0]              cnt_q;
  logic                    ready_q;
  logic                    resp_q;

  logic                    accept;
  logic [6:0]              size_mask;
  logic                    misaligned;
  logic                    too_wide;
  logic                    out_range;
  logic                    err;
  logic [7:0]              mask8;
  logic                    mem_we;
  logic [StrbW-1:0]        mem_be;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  assign accept     = HSELx && HREADY && HTRANS[1];
  assign size_mask  = 7'((8'd1 << HSIZE) - 8'd1);
  assign misaligned = |(HADDR[6:0] & size_mask);
  assign too_wide   = (32'd1 << HSIZE) > StrbW;
  assign out_range  = (HADDR >> Lsb) >= ADDR_WIDTH'(MEM_DEPTH);
  assign err        = misaligned || too_wide || out_range;

  // Outputs are registered alongside the state so they change only on HCLK.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= StIdle;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      resp_q  <= OKAY;
    end else begin
      case (state_q)
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q <= StData;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StErr1: begin
          state_q <= StErr2;
          ready_q <= 1'b1;
          resp_q  <= ERROR;
        end
        default: begin
          // StIdle, StData, StErr2: HREADYOUT is high, so a new address phase is taken.
          if (accept) begin
            addr_q  <= HADDR;
            write_q <= HWRITE;
            size_q  <= HSIZE;
            if (err) begin
              state_q <= StErr1;
              ready_q <= 1'b0;
              resp_q  <= ERROR;
            end else if (WAIT_STATES != 0) begin
              state_q <= StWait;
              ready_q <= 1'b0;
              resp_q  <= OKAY;
              cnt_q   <= 4'(WAIT_STATES - 1);
            end else begin
              state_q <= StData;
              ready_q <= 1'b1;
              resp_q  <= OKAY;
            end
          end else begin
            state_q <= StIdle;
            ready_q <= 1'b1;
            resp_q  <= OKAY;
          end
        end
      endcase
    end
  end

  assign mask8  = lane_mask(addr_q[2:0], size_q, StrbW);
  assign mem_we = (state_q == StData) && write_q && !HRESET;
  assign mem_be = HWSTRB & mask8[StrbW-1:0];

  ahb_modport_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_mem (
    .HCLK  (HCLK),
    .we    (mem_we),
    .be    (mem_be),
    .idx   (addr_q[Lsb +: IdxW]),
    .wdata (HWDATA),
    .rdata (mem_rdata)
  );

  assign HRDATA    = (state_q == StData && !write_q) ? mem_rdata : '0;
  assign HREADYOUT = ready_q;
  assign HRESP     = resp_q;

  logic unused_sigs;
  assign unused_sigs = ^{HTRANS[0], HBURST, HMASTLOCK, HPROT, addr_q, mask8};

endmodule

// File: tb/tb_ahb_modport.sv
module tb_ahb_modport;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        which;  // 0 selects the zero-wait instance, 1 the two-wait instance
  logic        hsel0, hsel2;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hmastlock;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [3:0]  hwstrb;
  logic [31:0] rdata0, rdata2;
  logic        ready0, ready2, resp0, resp2;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int cycles   = 0;

  xfer_t q[$];
  logic [7:0] m [0:1][0:1023];

  always #5 clk = ~clk;

  assign hsel0 = sel & ~which;
  assign hsel2 = sel & which;

  ahb_modport #(.WAIT_STATES(0)) u0 (
    .HCLK(clk), .HRESET(rst), .HSELx(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HMASTLOCK(hmastlock), .HPROT(hprot),
    .HWDATA(hwdata), .HWSTRB(hwstrb), .HREADY(ready0),
    .HRDATA(rdata0), .HREADYOUT(ready0), .HRESP(resp0)
  );

  ahb_modport #(.WAIT_STATES(2)) u2 (
    .HCLK(clk), .HRESET(rst), .HSELx(hsel2), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HMASTLOCK(hmastlock), .HPROT(hprot),
    .HWDATA(hwdata), .HWSTRB(hwstrb), .HREADY(ready2),
    .HRDATA(rdata2), .HREADYOUT(ready2), .HRESP(resp2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic s, input logic [1:0] t, input logic w, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] d, input logic [3:0] st);
    xfer_t x;
    x.sel = s; x.trans = t; x.wr = w; x.addr = a; x.size = sz; x.wdata = d; x.strb = st;
    q.push_back(x);
  endtask

  // Reference rules: bytes = 2**size, memory is 1024 bytes, word is 4 bytes.
  function automatic bit is_err(input xfer_t x);
    int unsigned nb;
    nb = 32'd1 << x.size;
    return (x.addr >= 32'd1024) || ((x.addr % nb) != 0) || (nb > 4);
  endfunction

  function automatic logic [31:0] model_word(input logic w, input logic [31:0] a);
    int base;
    base = int'(a) - int'(a % 4);
    return {m[w][base+3], m[w][base+2], m[w][base+1], m[w][base]};
  endfunction

  task automatic model_write(input logic w, input xfer_t x);
    int a, lane;
    for (int b = 0; b < (1 << x.size); b++) begin
      a    = int'(x.addr) + b;
      lane = a % 4;
      if (x.strb[lane]) m[w][a] = x.wdata[8*lane +: 8];
    end
  endtask

  task automatic drive_idle();
    sel = 1'b0; htrans = 2'd0; hwrite = 1'b0; haddr = '0; hsize = 3'd0;
  endtask

  // Pipelined manager: presents each queued address phase as soon as HREADYOUT is high
  // and checks every data phase response against the reference model.
  task automatic run_q();
    xfer_t       a, d;
    bit          a_v, d_v, last_rdy, e;
    int          waits, exp_waits;
    logic        ro, rs;
    logic [31:0] rd;
    a_v = 0; d_v = 0; last_rdy = 1; waits = 0;
    while (q.size() != 0 || a_v || d_v) begin
      if (last_rdy) begin
        if (a_v && a.sel && a.trans[1]) begin
          d = a; d_v = 1; waits = 0;
        end
        // Unaccepted phases still carry data so a stray write would be caught later.
        hwdata = a_v ? a.wdata : 32'h0;
        hwstrb = a_v ? a.strb : 4'h0;
        a_v = 0;
      end
      ro = which ? ready2 : ready0;
      rs = which ? resp2 : resp0;
      rd = which ? rdata2 : rdata0;
      if (d_v) begin
        e = is_err(d);
        exp_waits = e ? 1 : (which ? 2 : 0);
        if (!ro) begin
          waits++;
          check("wait_resp", 64'(rs), 64'(e));
          if (waits > 20) begin
            check("wait_timeout", 64'(waits), 64'(exp_waits));
            d_v = 0;
          end
        end else begin
          check("wait_count", 64'(waits), 64'(exp_waits));
          check("resp", 64'(rs), 64'(e));
          if (e) check("err_rdata", 64'(rd), 64'd0);
          else if (!d.wr) check("rdata", 64'(rd), 64'(model_word(which, d.addr)));
          else model_write(which, d);
          d_v = 0;
        end
      end else begin
        check("idle_ready", 64'(ro), 64'd1);
        check("idle_resp", 64'(rs), 64'd0);
      end
      if (ro) begin
        if (q.size() != 0) begin
          a = q.pop_front(); a_v = 1;
          sel = a.sel; htrans = a.trans; hwrite = a.wr; haddr = a.addr; hsize = a.size;
          hburst = 3'($urandom); hprot = 4'($urandom); hmastlock = 1'($urandom);
        end else begin
          drive_idle();
        end
      end
      last_rdy = ro;
      cycles++;
      if (cycles > 60000) begin
        check("cycle_budget", 64'(cycles), 64'd60000);
        q.delete(); a_v = 0; d_v = 0;
      end
      @(posedge clk); #1;
    end
    drive_idle();
  endtask

  initial begin
    logic [2:0]  sz;
    logic [31:0] ad;
    int          t;
    rst = 1'b1; which = 1'b0; drive_idle();
    hburst = '0; hmastlock = 1'b0; hprot = '0; hwdata = '0; hwstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ready0", 64'(ready0), 64'd1);
    check("rst_resp0", 64'(resp0), 64'd0);
    check("rst_rdata0", 64'(rdata0), 64'd0);
    check("rst_ready2", 64'(ready2), 64'd1);
    check("rst_resp2", 64'(resp2), 64'd0);
    check("rst_rdata2", 64'(rdata2), 64'd0);

    // Give both memories known contents.
    for (int w = 0; w < 2; w++) begin
      which = 1'(w);
      for (int i = 0; i < 256; i++) push(1, 2'd2, 1, 32'(4*i), 3'd2, $urandom, 4'hf);
      run_q();
    end

    // Zero-wait word write/read and byte write on the top lane.
    which = 1'b0;
    push(1, 2'd2, 1, 32'h10, 3'd2, 32'hDEADBEEF, 4'hf);
    push(1, 2'd2, 0, 32'h10, 3'd2, 32'h0, 4'h0);
    push(1, 2'd2, 1, 32'h13, 3'd0, 32'hAA000000, 4'b1000);
    push(1, 2'd2, 0, 32'h10, 3'd2, 32'h0, 4'h0);
    // Halfword write with strobes outside the window.
    push(1, 2'd2, 1, 32'h22, 3'd1, 32'h5566_7788, 4'hf);
    push(1, 2'd3, 0, 32'h20, 3'd2, 32'h0, 4'h0);
    // Errors: out of range, misaligned, too wide; writes must not land.
    push(1, 2'd2, 0, 32'h400, 3'd2, 32'h0, 4'h0);
    push(1, 2'd2, 1, 32'h2, 3'd2, 32'hFFFF_FFFF, 4'hf);
    push(1, 2'd2, 1, 32'h8, 3'd3, 32'h1234_5678, 4'hf);
    push(1, 2'd2, 0, 32'h0, 3'd2, 32'h0, 4'h0);
    push(1, 2'd2, 0, 32'h8, 3'd2, 32'h0, 4'h0);
    // IDLE, BUSY and deselected NONSEQ writes must not touch memory.
    push(1, 2'd0, 1, 32'h30, 3'd2, 32'h1111_1111, 4'hf);
    push(1, 2'd1, 1, 32'h30, 3'd2, 32'h2222_2222, 4'hf);
    push(0, 2'd2, 1, 32'h30, 3'd2, 32'h3333_3333, 4'hf);
    push(1, 2'd2, 0, 32'h30, 3'd2, 32'h0, 4'h0);
    run_q();

    // Two-wait instance: back-to-back reads, errors and a write.
    which = 1'b1;
    push(1, 2'd2, 0, 32'h40, 3'd2, 32'h0, 4'h0);
    push(1, 2'd3, 0, 32'h44, 3'd2, 32'h0, 4'h0);
    push(1, 2'd2, 1, 32'h44, 3'd2, 32'hCAFE_F00D, 4'hf);
    push(1, 2'd2, 0, 32'h44, 3'd2, 32'h0, 4'h0);
    push(1, 2'd2, 0, 32'h400, 3'd2, 32'h0, 4'h0);
    push(1, 2'd2, 0, 32'h2, 3'd2, 32'h0, 4'h0);
    run_q();

    // Reset during the WAIT of a write aborts it.
    which = 1'b1; sel = 1'b1; haddr = 32'h20; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    hwdata = 32'h1234_5678; hwstrb = 4'hf; drive_idle();
    check("rst_in_wait_low", 64'(ready2), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", 64'(ready2), 64'd1);
    check("abort_resp", 64'(resp2), 64'd0);
    check("abort_rdata", 64'(rdata2), 64'd0);
    @(posedge clk); #1;
    push(1, 2'd2, 0, 32'h20, 3'd2, 32'h0, 4'h0);
    run_q();

    // Randomised mix on both instances.
    for (int w = 0; w < 2; w++) begin
      which = 1'(w);
      for (int i = 0; i < 120; i++) begin
        sz = 3'($urandom_range(0, 3));
        ad = 32'($urandom_range(0, 1039));
        if ($urandom_range(0, 4) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
        t = $urandom_range(0, 5);
        push(($urandom_range(0, 9) != 0), (t < 2) ? 2'(t) : ((t < 4) ? 2'd2 : 2'd3),
             1'($urandom_range(0, 1)), ad, sz, $urandom, 4'($urandom_range(0, 15)));
      end
      run_q();
    end

    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end

endmodule

// File: doc/ahb_modport.md
Name: ahb_modport

Overview:
AHB-Lite subordinate endpoint that implements the subordinate modport of the team's AHB interface: a word-organised, byte-strobed local memory. It is selected by the decoder via HSELx. It supports programmable wait states and the two-cycle ERROR response. It sits behind the bus interconnect and serves as the reference target for the AHB VIP manager, monitor and protocol assertions.

Parameters:
ADDR_WIDTH, 32, HADDR width
DATA_WIDTH, 32, HWDATA/HRDATA width (32 or 64)
MEM_DEPTH, 256, number of DATA_WIDTH words; byte size = MEM_DEPTH*DATA_WIDTH/8
WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY NONSEQ/SEQ data phase (0..15)

Ports:
HCLK  in  1  bus clock; all logic on rising edge
HRESET  in  1  synchronous reset, active-high
HSELx  in  1  subordinate select from decoder
HADDR  in  ADDR_WIDTH  address-phase address
HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
HWRITE  in  1  1=write
HSIZE  in  3  bytes = 2**HSIZE
HBURST  in  3  burst type; accepted, not checked
HMASTLOCK  in  1  accepted, ignored
HPROT  in  4  accepted, ignored
HWDATA  in  DATA_WIDTH  data-phase write data
HWSTRB  in  DATA_WIDTH/8  data-phase byte strobes
HREADY  in  1  bus-level ready (muxed HREADYOUT)
HRDATA  out  DATA_WIDTH  read data
HREADYOUT  out  1  transfer-done
HRESP  out  1  0=OKAY, 1=ERROR

Behaviour:
- Reset (HRESET=1 at a clock edge): HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, pending transfer discarded. Memory is not cleared.
- Address-phase accept condition: HSELx && HREADY && HTRANS[1]. Capture addr, write, size and error flag into data-phase registers.
- IDLE/BUSY, or not selected: no data phase; the next cycle is OKAY with zero wait (HREADYOUT=1, HRESP=0).
- Error flag is set when any of the following holds:
  - word index HADDR/(DATA_WIDTH/8) >= MEM_DEPTH;
  - HADDR not aligned to 2**HSIZE;
  - 2**HSIZE > DATA_WIDTH/8.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=0.
  - Accepted transfer with error -> ERR1: HRESP=1, HREADYOUT=0, no memory access.
  - ERR1 -> ERR2: HRESP=1, HREADYOUT=1.
  - Accepted OKAY transfer with WAIT_STATES>0 -> WAIT: HREADYOUT=0, HRESP=0, counter loaded with WAIT_STATES-1, decrements each cycle, exits to DATA at 0.
  - Accepted OKAY transfer with WAIT_STATES=0 -> DATA directly: HREADYOUT=1, HRESP=0.
- Pipelining: in any cycle with HREADYOUT=1 (IDLE, DATA, ERR2), a new address phase is evaluated. Next state is ERR1/WAIT/DATA for an accepted transfer, else IDLE. Back-to-back zero-wait transfers sustain one transfer per cycle.
- Write: in the DATA cycle, byte lane i is written iff HWSTRB[i] and lane i lies within the size-aligned window HADDR[lsb]..+2**HSIZE-1. Lanes are little-endian (lane 0 = HWDATA[7:0]).
- Read: HRDATA presents the full addressed word combinationally from the captured address during DATA. In all other states HRDATA=0.
- Read-after-write to the same word in consecutive transfers returns the new data. The write commits at the end of the DATA cycle; the next read's DATA cycle is later.
- A reset mid-WAIT or mid-ERR aborts the transfer; no write occurs.

Decomposition:
- Package ahb_pkg: htrans_e (IDLE, BUSY, NONSEQ, SEQ), hresp constants OKAY/ERROR, hsize_e, and a function returning the byte-lane mask for (addr, size, DATA_WIDTH).
- Sub-module ahb_modport_mem: single-port byte-enabled RAM, synchronous write, combinational read. The FSM and address checks stay in the top.

Test Plan:
- WAIT_STATES=0: write word 0xDEADBEEF at 0x10, then read 0x10 -> HRDATA=0xDEADBEEF, HREADYOUT never low, HRESP=0.
- Byte write HSIZE=0, HADDR=0x13, HWDATA=0xAA000000, HWSTRB=4'b1000; then read word 0x10 -> 0xAAADBEEF.
- WAIT_STATES=2: NONSEQ read -> HREADYOUT=0 for exactly 2 cycles, then 1 with valid data; back-to-back reads each add 2 waits.
- Word read at 0x400 (out of range, MEM_DEPTH=256) -> HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1, then OKAY. Same response for word access at misaligned 0x2; memory unchanged.
- IDLE and BUSY cycles (and NONSEQ with HSELx=0) -> HREADYOUT=1, HRESP=0 next cycle; no memory write.
- Assert HRESET during WAIT of a write -> outputs return to HREADYOUT=1, HRESP=0, HRDATA=0; target word unchanged on readback.
